// File: rtl/cv32e40p_rf_wb_arbiter.sv
// ----------------------------------------------------------------------------
// cv32e40p_rf_wb_arbiter
//
// Writeback initiator for the two register-file write ports.
//   - EX (ALU) results go through a one-entry holding stage to write port A.
//   - LSU and APU results are merged through a small FIFO to write port B.
//   - Port B wins inside the register file, so when the A stage and the FIFO
//     head target the same register, B is written first and A is held one
//     cycle. FIFO results are older, so the later A write leaves the final
//     value in the register.
//   - pending_o flags every register with a write still in flight, for the
//     ID-stage hazard logic.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   ex_valid_i/waddr/wdata/ready  EX result handshake
//   lsu_valid_i/.../lsu_ready_o   load result handshake
//   apu_valid_i/.../apu_ready_o   APU result handshake
//   waddr_a_o/wdata_a_o/we_a_o    register-file write port A
//   waddr_b_o/wdata_b_o/we_b_o    register-file write port B
//   pending_o                     bit i set while a write to register i waits
// ----------------------------------------------------------------------------
module cv32e40p_rf_wb_arbiter #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ex_valid_i,
  input  logic [ADDR_WIDTH-1:0]    ex_waddr_i,
  input  logic [DATA_WIDTH-1:0]    ex_wdata_i,
  output logic                     ex_ready_o,
  input  logic                     lsu_valid_i,
  input  logic [ADDR_WIDTH-1:0]    lsu_waddr_i,
  input  logic [DATA_WIDTH-1:0]    lsu_wdata_i,
  output logic                     lsu_ready_o,
  input  logic                     apu_valid_i,
  input  logic [ADDR_WIDTH-1:0]    apu_waddr_i,
  input  logic [DATA_WIDTH-1:0]    apu_wdata_i,
  output logic                     apu_ready_o,
  output logic [ADDR_WIDTH-1:0]    waddr_a_o,
  output logic [DATA_WIDTH-1:0]    wdata_a_o,
  output logic                     we_a_o,
  output logic [ADDR_WIDTH-1:0]    waddr_b_o,
  output logic [DATA_WIDTH-1:0]    wdata_b_o,
  output logic                     we_b_o,
  output logic [2**ADDR_WIDTH-1:0] pending_o
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int NREG  = 2**ADDR_WIDTH;

  // A stage
  logic                  a_valid_q;
  logic [ADDR_WIDTH-1:0] a_waddr_q;
  logic [DATA_WIDTH-1:0] a_wdata_q;

  // Port-B FIFO
  logic [ADDR_WIDTH-1:0] mem_waddr_r [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] mem_wdata_r [FIFO_DEPTH];
  logic [CNT_W-1:0]      count_r;
  logic [PTR_W-1:0]      rd_ptr_r;
  logic [PTR_W-1:0]      wr_ptr_r;

  logic                  fifo_nonempty_s;
  logic [ADDR_WIDTH-1:0] head_waddr_s;
  logic                  collide_s;
  logic                  a_fire_s;
  logic [CNT_W-1:0]      free_s;
  logic                  ex_keep_s;
  logic                  push_lsu_s;
  logic                  push_apu_s;
  logic                  pop_s;
  logic [PTR_W-1:0]      wr_idx_apu_s;
  logic [CNT_W-1:0]      count_next_s;
  logic [NREG-1:0]       pending_s;

  // Head-of-FIFO view, collision detection and producer readies.
  always_comb begin
    fifo_nonempty_s = (count_r != {CNT_W{1'b0}});
    head_waddr_s    = mem_waddr_r[rd_ptr_r];
    collide_s       = a_valid_q && fifo_nonempty_s && (a_waddr_q == head_waddr_s);
    a_fire_s        = a_valid_q && !collide_s;
    // Registered count only: a pop in this cycle does not free a slot for
    // this cycle's pushes, which keeps the readies off the pop path.
    free_s          = CNT_W'(FIFO_DEPTH) - count_r;
    ex_ready_o      = !rst && (!a_valid_q || a_fire_s);
    lsu_ready_o     = !rst && (free_s >= CNT_W'(1'b1));
    // APU yields the last free slot to a waiting LSU result.
    apu_ready_o     = !rst && ((free_s >= CNT_W'(2'd2)) ||
                               ((free_s >= CNT_W'(1'b1)) && !lsu_valid_i));
  end

  // Accepted transfers; writes to x0 complete the handshake but are dropped.
  always_comb begin
    ex_keep_s    = ex_valid_i  && ex_ready_o  && (ex_waddr_i  != {ADDR_WIDTH{1'b0}});
    push_lsu_s   = lsu_valid_i && lsu_ready_o && (lsu_waddr_i != {ADDR_WIDTH{1'b0}});
    push_apu_s   = apu_valid_i && apu_ready_o && (apu_waddr_i != {ADDR_WIDTH{1'b0}});
    pop_s        = fifo_nonempty_s;
    // LSU is written first (older); APU lands in the following slot.
    if (push_lsu_s) begin
      wr_idx_apu_s = wr_ptr_r + PTR_W'(1'b1);
    end else begin
      wr_idx_apu_s = wr_ptr_r;
    end
    count_next_s = count_r + CNT_W'(push_lsu_s) + CNT_W'(push_apu_s) - CNT_W'(pop_s);
  end

  // Pending-write mask from the A stage and every occupied FIFO slot.
  always_comb begin
    pending_s = {NREG{1'b0}};
    pending_s[a_waddr_q] = a_valid_q;
    for (int k = 0; k < FIFO_DEPTH; k++) begin
      // Slot k is occupied when its distance from rd_ptr is below count.
      pending_s[mem_waddr_r[k]] = pending_s[mem_waddr_r[k]] |
                                  (CNT_W'(PTR_W'(k) - rd_ptr_r) < count_r);
    end
    pending_s[0] = 1'b0;
  end

  // Write-port drive; enables are blocked while reset discards in-flight data.
  always_comb begin
    we_a_o    = a_fire_s && !rst;
    waddr_a_o = a_waddr_q;
    wdata_a_o = a_wdata_q;
    we_b_o    = fifo_nonempty_s && !rst;
    waddr_b_o = head_waddr_s;
    wdata_b_o = mem_wdata_r[rd_ptr_r];
    pending_o = pending_s;
  end

  // A-stage holding register: load on EX accept, release on a non-colliding write.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_valid_q <= 1'b0;
      a_waddr_q <= {ADDR_WIDTH{1'b0}};
      a_wdata_q <= {DATA_WIDTH{1'b0}};
    end else if (ex_keep_s) begin
      a_valid_q <= 1'b1;
      a_waddr_q <= ex_waddr_i;
      a_wdata_q <= ex_wdata_i;
    end else if (a_fire_s) begin
      a_valid_q <= 1'b0;
    end
  end

  // FIFO pointers, occupancy and storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r  <= {CNT_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      for (int k = 0; k < FIFO_DEPTH; k++) begin
        mem_waddr_r[k] <= {ADDR_WIDTH{1'b0}};
        mem_wdata_r[k] <= {DATA_WIDTH{1'b0}};
      end
    end else begin
      count_r  <= count_next_s;
      rd_ptr_r <= rd_ptr_r + PTR_W'(pop_s);
      wr_ptr_r <= wr_ptr_r + PTR_W'(push_lsu_s) + PTR_W'(push_apu_s);
      if (push_lsu_s) begin
        mem_waddr_r[wr_ptr_r] <= lsu_waddr_i;
        mem_wdata_r[wr_ptr_r] <= lsu_wdata_i;
      end
      if (push_apu_s) begin
        mem_waddr_r[wr_idx_apu_s] <= apu_waddr_i;
        mem_wdata_r[wr_idx_apu_s] <= apu_wdata_i;
      end
    end
  end

endmodule

// File: tb/tb_cv32e40p_rf_wb_arbiter.sv
// ----------------------------------------------------------------------------
// Directed self-checking bench for cv32e40p_rf_wb_arbiter (default params).
// Inputs change 1 time unit after the rising edge; outputs are checked 1 time
// unit after that, well away from the next edge.
// ----------------------------------------------------------------------------
module tb_cv32e40p_rf_wb_arbiter;

  localparam int AW = 6;
  localparam int DW = 32;

  logic          clk;
  logic          rst;
  logic          ex_valid, lsu_valid, apu_valid;
  logic [AW-1:0] ex_waddr, lsu_waddr, apu_waddr;
  logic [DW-1:0] ex_wdata, lsu_wdata, apu_wdata;
  logic          ex_ready, lsu_ready, apu_ready;
  logic [AW-1:0] waddr_a, waddr_b;
  logic [DW-1:0] wdata_a, wdata_b;
  logic          we_a, we_b;
  logic [63:0]   pending;

  int n_checks = 0;
  int n_fail   = 0;

  cv32e40p_rf_wb_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .ex_valid_i  (ex_valid),
    .ex_waddr_i  (ex_waddr),
    .ex_wdata_i  (ex_wdata),
    .ex_ready_o  (ex_ready),
    .lsu_valid_i (lsu_valid),
    .lsu_waddr_i (lsu_waddr),
    .lsu_wdata_i (lsu_wdata),
    .lsu_ready_o (lsu_ready),
    .apu_valid_i (apu_valid),
    .apu_waddr_i (apu_waddr),
    .apu_wdata_i (apu_wdata),
    .apu_ready_o (apu_ready),
    .waddr_a_o   (waddr_a),
    .wdata_a_o   (wdata_a),
    .we_a_o      (we_a),
    .waddr_b_o   (waddr_b),
    .wdata_b_o   (wdata_b),
    .we_b_o      (we_b),
    .pending_o   (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Backpressure table: inputs per cycle and expected readies / port-B write.
  // LSU entry k targets x(10+k) with data 0x100+k; APU entry k x(20+k), 0x200+k.
  int t_lv [9] = '{1, 1, 1, 1, 0, 0, 0, 0, 0};
  int t_av [9] = '{1, 1, 1, 1, 1, 0, 0, 0, 0};
  int t_li [9] = '{0, 1, 2, 3, 0, 0, 0, 0, 0};
  int t_ai [9] = '{0, 1, 2, 2, 2, 0, 0, 0, 0};
  int t_lr [9] = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
  int t_ar [9] = '{1, 1, 0, 0, 1, 1, 1, 1, 1};
  int t_we [9] = '{0, 1, 1, 1, 1, 1, 1, 1, 0};
  int t_ob [9] = '{0, 10, 20, 11, 21, 12, 13, 22, 0};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ex_valid  = 1'b0;
    lsu_valid = 1'b0;
    apu_valid = 1'b0;
  endtask

  initial begin
    int exp_data;

    // 1. Reset with every producer requesting.
    rst = 1'b1;
    ex_valid = 1'b1;  ex_waddr = 6'd3;  ex_wdata = 32'h0000_0003;
    lsu_valid = 1'b1; lsu_waddr = 6'd4; lsu_wdata = 32'h0000_0004;
    apu_valid = 1'b1; apu_waddr = 6'd6; apu_wdata = 32'h0000_0006;
    tick();
    chk("rst_ex_ready",  64'(ex_ready),  64'd0);
    chk("rst_lsu_ready", 64'(lsu_ready), 64'd0);
    chk("rst_apu_ready", 64'(apu_ready), 64'd0);
    tick();
    chk("rst_we_a",    64'(we_a),    64'd0);
    chk("rst_we_b",    64'(we_b),    64'd0);
    chk("rst_pending", pending,      64'd0);
    chk("rst_waddr_a", 64'(waddr_a), 64'd0);
    chk("rst_wdata_b", 64'(wdata_b), 64'd0);
    rst = 1'b0;
    idle_inputs();
    #1;
    chk("post_rst_ex_ready",  64'(ex_ready),  64'd1);
    chk("post_rst_apu_ready", 64'(apu_ready), 64'd1);
    tick();
    chk("post_rst_we_a",    64'(we_a),  64'd0);
    chk("post_rst_we_b",    64'(we_b),  64'd0);
    chk("post_rst_pending", pending,    64'd0);

    // 2. EX only: x5 = 0xDEADBEEF.
    ex_valid = 1'b1; ex_waddr = 6'd5; ex_wdata = 32'hDEAD_BEEF;
    #1;
    chk("ex_ready", 64'(ex_ready), 64'd1);
    tick();
    idle_inputs();
    chk("ex_we_a",    64'(we_a),    64'd1);
    chk("ex_waddr_a", 64'(waddr_a), 64'd5);
    chk("ex_wdata_a", 64'(wdata_a), 64'hDEAD_BEEF);
    chk("ex_pending", pending,      64'h20);
    tick();
    chk("ex_we_a_done",    64'(we_a), 64'd0);
    chk("ex_pending_done", pending,   64'd0);

    // 3. Dual push into empty FIFO: LSU x7=0x11 then APU x8=0x22.
    lsu_valid = 1'b1; lsu_waddr = 6'd7; lsu_wdata = 32'h11;
    apu_valid = 1'b1; apu_waddr = 6'd8; apu_wdata = 32'h22;
    #1;
    chk("dual_lsu_ready", 64'(lsu_ready), 64'd1);
    chk("dual_apu_ready", 64'(apu_ready), 64'd1);
    tick();
    idle_inputs();
    chk("dual_we_b_1",    64'(we_b),    64'd1);
    chk("dual_waddr_b_1", 64'(waddr_b), 64'd7);
    chk("dual_wdata_b_1", 64'(wdata_b), 64'h11);
    chk("dual_pending_1", pending,      64'h180);
    tick();
    chk("dual_we_b_2",    64'(we_b),    64'd1);
    chk("dual_waddr_b_2", 64'(waddr_b), 64'd8);
    chk("dual_wdata_b_2", 64'(wdata_b), 64'h22);
    chk("dual_pending_2", pending,      64'h100);
    tick();
    chk("dual_we_b_3",    64'(we_b), 64'd0);
    chk("dual_pending_3", pending,   64'd0);

    // 4. Collision on x9: A holds 0xAAAA, FIFO head holds 0xBBBB.
    ex_valid = 1'b1;  ex_waddr = 6'd9;  ex_wdata = 32'hAAAA;
    lsu_valid = 1'b1; lsu_waddr = 6'd9; lsu_wdata = 32'hBBBB;
    tick();
    idle_inputs();
    #1;
    chk("col_we_b",     64'(we_b),     64'd1);
    chk("col_waddr_b",  64'(waddr_b),  64'd9);
    chk("col_wdata_b",  64'(wdata_b),  64'hBBBB);
    chk("col_we_a",     64'(we_a),     64'd0);
    chk("col_ex_ready", 64'(ex_ready), 64'd0);
    chk("col_pending",  pending,       64'h200);
    tick();
    chk("col_we_a_2",     64'(we_a),     64'd1);
    chk("col_waddr_a_2",  64'(waddr_a),  64'd9);
    chk("col_wdata_a_2",  64'(wdata_a),  64'hAAAA);
    chk("col_we_b_2",     64'(we_b),     64'd0);
    chk("col_ex_ready_2", 64'(ex_ready), 64'd1);
    tick();
    chk("col_we_a_3",    64'(we_a), 64'd0);
    chk("col_pending_3", pending,   64'd0);

    // 5. x0 targets: handshake completes, nothing is written.
    ex_valid = 1'b1;  ex_waddr = 6'd0;  ex_wdata = 32'h1234;
    lsu_valid = 1'b1; lsu_waddr = 6'd0; lsu_wdata = 32'h5678;
    #1;
    chk("x0_ex_ready",  64'(ex_ready),  64'd1);
    chk("x0_lsu_ready", 64'(lsu_ready), 64'd1);
    tick();
    idle_inputs();
    chk("x0_we_a",    64'(we_a), 64'd0);
    chk("x0_we_b",    64'(we_b), 64'd0);
    chk("x0_pending", pending,   64'd0);
    tick();
    chk("x0_we_a_2", 64'(we_a), 64'd0);
    chk("x0_we_b_2", 64'(we_b), 64'd0);

    // 6. Backpressure: LSU and APU both streaming into a 4-deep FIFO.
    for (int c = 0; c < 9; c++) begin
      lsu_valid = (t_lv[c] != 0);
      lsu_waddr = 6'(10 + t_li[c]);
      lsu_wdata = 32'(32'h100 + t_li[c]);
      apu_valid = (t_av[c] != 0);
      apu_waddr = 6'(20 + t_ai[c]);
      apu_wdata = 32'(32'h200 + t_ai[c]);
      #1;
      chk($sformatf("bp_lsu_ready_c%0d", c), 64'(lsu_ready), 64'(t_lr[c]));
      chk($sformatf("bp_apu_ready_c%0d", c), 64'(apu_ready), 64'(t_ar[c]));
      chk($sformatf("bp_we_b_c%0d", c),      64'(we_b),      64'(t_we[c]));
      if (t_we[c] != 0) begin
        exp_data = (t_ob[c] < 20) ? (32'h100 + t_ob[c] - 10) : (32'h200 + t_ob[c] - 20);
        chk($sformatf("bp_waddr_b_c%0d", c), 64'(waddr_b), 64'(t_ob[c]));
        chk($sformatf("bp_wdata_b_c%0d", c), 64'(wdata_b), 64'(exp_data));
      end
      if (c == 3) begin
        chk("bp_pending_c3", pending, (64'd1 << 11) | (64'd1 << 12) | (64'd1 << 21));
      end
      tick();
    end
    idle_inputs();
    chk("bp_we_b_end",    64'(we_b), 64'd0);
    chk("bp_pending_end", pending,   64'd0);

    // 7. Reset while A stage and FIFO both hold results.
    ex_valid = 1'b1;  ex_waddr = 6'd4;  ex_wdata = 32'h44;
    lsu_valid = 1'b1; lsu_waddr = 6'd3; lsu_wdata = 32'h33;
    tick();
    idle_inputs();
    chk("mid_pending", pending,   64'h18);
    chk("mid_we_a",    64'(we_a), 64'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_we_a",     64'(we_a),     64'd0);
    chk("mid_rst_we_b",     64'(we_b),     64'd0);
    chk("mid_rst_ex_ready", 64'(ex_ready), 64'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("mid_after_we_a",    64'(we_a),    64'd0);
    chk("mid_after_we_b",    64'(we_b),    64'd0);
    chk("mid_after_pending", pending,      64'd0);
    chk("mid_after_waddr_a", 64'(waddr_a), 64'd0);
    chk("mid_after_waddr_b", 64'(waddr_b), 64'd0);
    tick();
    chk("mid_idle_we_b", 64'(we_b), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
